rate_divider_sel: RTL and testbench

Parametrised selectable-rate divider: generates a square-wave output and a one-cycle rate tick from the system clock. The rate is chosen at run time from 2^SEL_W integer multiples of a base frequency. It is the next generation of the 2/4/6/8 Hz divisor selector: divisors are computed from parameters at elaboration, and rate changes are applied glitch-free on a half-period boundary. It feeds blink/scan logic and display-rate counters in the lab top levels.

---
 rtl/rate_divider_sel.sv | 95 +++++++++
 tb/tb_rate_divider_sel.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/rate_divider_sel.sv
// Selectable-rate divider: 50% square wave plus rising-edge tick at (k+1)*STEP_HZ.
// Define RATE_DIVIDER_SEL_SYNC_EN to put a two-flop synchroniser on sel.
module rate_divider_sel #(
  parameter int CLK_HZ  = 50000000,
  parameter int STEP_HZ = 2,
  parameter int SEL_W   = 2,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] half_cnt,
  output logic             rate_upd
);

  localparam int NUM = 2 ** SEL_W;
  localparam longint HMAX = longint'((64'd1 << CNT_W) - 64'd1);

  function automatic longint calc_h(input int k);
    longint v;
    v = longint'(CLK_HZ) / (longint'(2) * longint'(STEP_HZ) * longint'(k + 1));
    if (v == 0) v = 1;
    return v;
  endfunction

  logic [CNT_W-1:0] h_tab [NUM];
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] h_cur;
  logic [SEL_W-1:0] act_sel;
  logic [SEL_W-1:0] sel_s;

  for (genvar k = 0; k < NUM; k++) begin : g_tab
    if (calc_h(k) > HMAX) begin : g_err
      $error("rate_divider_sel: half-period %0d does not fit in CNT_W bits", k);
    end
    assign h_tab[k] = CNT_W'(calc_h(k));
  end

  assign h_cur    = h_tab[act_sel];
  assign half_cnt = h_cur;

`ifdef RATE_DIVIDER_SEL_SYNC_EN
  logic [SEL_W-1:0] sel_m;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_m <= '0;
      sel_s <= '0;
    end else begin
      sel_m <= sel;
      sel_s <= sel_m;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_s <= '0;
    else        sel_s <= sel;
  end
`endif

  // Rate switches only on a terminal event (or at once while frozen), so no runt half-periods.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      rate_upd <= 1'b0;
      act_sel  <= '0;
    end else begin
      tick     <= 1'b0;
      rate_upd <= 1'b0;
      if (en) begin
        if (cnt == h_cur - CNT_W'(1)) begin
          cnt     <= '0;
          clk_out <= ~clk_out;
          tick    <= ~clk_out;
          if (sel_s != act_sel) begin
            act_sel  <= sel_s;
            rate_upd <= 1'b1;
          end
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else if (sel_s != act_sel) begin
        act_sel  <= sel_s;
        cnt      <= '0;
        rate_upd <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rate_divider_sel.sv
// Directed bench for rate_divider_sel with CLK_HZ=48, STEP_HZ=2, SEL_W=2, CNT_W=8 (H = 12, 6, 4, 3).
module tb_rate_divider_sel;

`ifdef RATE_DIVIDER_SEL_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] sel;
  logic       clk_out;
  logic       tick;
  logic [7:0] half_cnt;
  logic       rate_upd;

  int total = 0;
  int bad   = 0;

  rate_divider_sel #(
    .CLK_HZ (48),
    .STEP_HZ(2),
    .SEL_W  (2),
    .CNT_W  (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .sel     (sel),
    .clk_out (clk_out),
    .tick    (tick),
    .half_cnt(half_cnt),
    .rate_upd(rate_upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int e, input logic co, input logic tk,
                          input logic ru, input int hc);
    chk($sformatf("%s clk_out e%0d", tag, e), 32'(clk_out), 32'(co));
    chk($sformatf("%s tick e%0d", tag, e), 32'(tick), 32'(tk));
    chk($sformatf("%s rate_upd e%0d", tag, e), 32'(rate_upd), 32'(ru));
    chk($sformatf("%s half_cnt e%0d", tag, e), 32'(half_cnt), 32'(hc));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds reset over two edges; the next posedge after return is edge 1.
  task automatic do_reset(input logic [1:0] s);
    rst_n = 1'b0;
    en    = 1'b1;
    sel   = s;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    sel   = 2'd0;
    #2;
    chk_outs("reset", 0, 1'b0, 1'b0, 1'b0, 12);

    // A: sel=0, free run; rises at 12, falls at 24, ticks 12/36/60
    do_reset(2'd0);
    chk_outs("A rel", 0, 1'b0, 1'b0, 1'b0, 12);
    for (int e = 1; e <= 60; e++) begin
      step();
      chk_outs("A", e, ((e / 12) % 2) == 1, (e % 24) == 12, 1'b0, 12);
    end

    // B: request sel=3 at cycle 5; applied at edge 12, then 3-cycle half-periods
    do_reset(2'd0);
    for (int e = 1; e <= 11; e++) begin
      step();
      if (e == 5) sel = 2'd3;
      chk_outs("B", e, 1'b0, 1'b0, 1'b0, 12);
    end
    step();
    chk_outs("B", 12, 1'b1, 1'b1, 1'b1, 3);
    for (int j = 1; j <= 12; j++) begin
      step();
      chk_outs("B", 12 + j, ((j / 3) % 2) == 0, (j % 6) == 0, 1'b0, 3);
    end

    // C: 0->2->0 bounce inside one half-period is not applied
    do_reset(2'd0);
    for (int e = 1; e <= 48; e++) begin
      step();
      if (e == 14) sel = 2'd2;
      if (e == 17) sel = 2'd0;
      chk_outs("C", e, ((e / 12) % 2) == 1, (e % 24) == 12, 1'b0, 12);
    end

    // D: en low for 5 edges after edge 5 shifts everything by 5
    do_reset(2'd0);
    for (int e = 1; e <= 65; e++) begin
      step();
      if (e == 5)  en = 1'b0;
      if (e == 10) en = 1'b1;
      if (e >= 6 && e <= 10)
        chk_outs("D", e, 1'b0, 1'b0, 1'b0, 12);
      else if (e > 10)
        chk_outs("D", e, (((e - 5) / 12) % 2) == 1, ((e - 5) % 24) == 12, 1'b0, 12);
    end

    // E: while frozen, sel 0->1 applies immediately and restarts the count
    do_reset(2'd0);
    for (int e = 1; e <= 5; e++) step();
    en = 1'b0;
    step();
    sel = 2'd1;
    for (int e = 7; e <= 10; e++) begin
      step();
      chk_outs("E", e, 1'b0, 1'b0, e == 7 + SYNC_LAT, (e >= 7 + SYNC_LAT) ? 6 : 12);
    end
    en = 1'b1;
    for (int e = 11; e <= 16; e++) begin
      step();
      chk_outs("E", e, e == 16, e == 16, 1'b0, 6);
    end

    // F: async reset mid-half-period with sel=3 active, then re-apply after release
    do_reset(2'd3);
    for (int e = 1; e <= 19; e++) begin
      step();
      if (e == 12) chk_outs("F pre", e, 1'b1, 1'b1, 1'b1, 3);
      if (e == 18) chk_outs("F pre", e, 1'b1, 1'b1, 1'b0, 3);
    end
    chk_outs("F pre", 19, 1'b1, 1'b0, 1'b0, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("F async", 19, 1'b0, 1'b0, 1'b0, 12);
    step();
    step();
    rst_n = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      step();
      chk_outs("F post", e, 1'b0, 1'b0, 1'b0, 12);
    end
    step();
    chk_outs("F post", 12, 1'b1, 1'b1, 1'b1, 3);
    for (int j = 1; j <= 12; j++) begin
      step();
      chk_outs("F post", 12 + j, ((j / 3) % 2) == 0, (j % 6) == 0, 1'b0, 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
